// File: rtl/imm_extend_pipe.sv
// Decode-to-execute immediate generator: extension is registered one cycle after acceptance,
// and a second (skid) entry absorbs one extra input when execute stalls, so nothing is dropped.
module imm_extend_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 3,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instr,
   input  logic [IMM_WIDTH-1:0]  ImmSrc,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ExtImm,
   output logic                  illegal,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] imm;
      logic                  illegal;
      logic [TAG_WIDTH-1:0]  tag;
   } entry_t;

   localparam logic [IMM_WIDTH-1:0] SRC_I     = IMM_WIDTH'(0);
   localparam logic [IMM_WIDTH-1:0] SRC_S     = IMM_WIDTH'(1);
   localparam logic [IMM_WIDTH-1:0] SRC_B     = IMM_WIDTH'(2);
   localparam logic [IMM_WIDTH-1:0] SRC_J     = IMM_WIDTH'(3);
   localparam logic [IMM_WIDTH-1:0] SRC_U     = IMM_WIDTH'(4);
   localparam logic [IMM_WIDTH-1:0] SRC_SHAMT = IMM_WIDTH'(5);
   localparam logic [IMM_WIDTH-1:0] SRC_ZIMM  = IMM_WIDTH'(6);

   entry_t in_ent;
   entry_t out_reg;
   entry_t skid_reg;
   logic   out_full;
   logic   skid_full;
   logic   accept;
   logic   consume;

   logic [11:0] i_imm;
   logic [11:0] s_imm;
   logic [12:0] b_imm;
   logic [20:0] j_imm;
   logic [31:0] u_imm;
   logic        unused_opcode;

   assign i_imm = instr[31:20];
   assign s_imm = {instr[31:25], instr[11:7]};
   assign b_imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign j_imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign u_imm = {instr[31:12], 12'b0};
   assign unused_opcode = ^instr[6:0];

   // Signed casts sign-extend from bit 31 of the instruction to the full output width.
   always_comb begin
      in_ent         = '0;
      in_ent.tag     = in_tag;
      case (ImmSrc)
         SRC_I:     in_ent.imm = DATA_WIDTH'($signed(i_imm));
         SRC_S:     in_ent.imm = DATA_WIDTH'($signed(s_imm));
         SRC_B:     in_ent.imm = DATA_WIDTH'($signed(b_imm));
         SRC_J:     in_ent.imm = DATA_WIDTH'($signed(j_imm));
         SRC_U:     in_ent.imm = DATA_WIDTH'($signed(u_imm));
         SRC_SHAMT: in_ent.imm = (DATA_WIDTH == 64) ? DATA_WIDTH'(instr[25:20])
                                                    : DATA_WIDTH'(instr[24:20]);
         SRC_ZIMM:  in_ent.imm = DATA_WIDTH'(instr[19:15]);
         default:   in_ent.illegal = 1'b1;
      endcase
   end

   // Ready depends only on skid occupancy, keeping out_ready off the input timing path.
   assign in_ready = !skid_full && !rst;
   assign accept   = in_valid && in_ready;
   assign consume  = out_full && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_full  <= 1'b0;
         skid_full <= 1'b0;
         out_reg   <= '0;
         skid_reg  <= '0;
      end else if (flush) begin
         out_full  <= 1'b0;
         skid_full <= 1'b0;
      end else if (!out_full || consume) begin
         if (skid_full) begin
            out_reg   <= skid_reg;
            out_full  <= 1'b1;
            skid_full <= 1'b0;
         end else begin
            out_full <= accept;
            if (accept) begin
               out_reg <= in_ent;
            end
         end
      end else if (accept) begin
         skid_reg  <= in_ent;
         skid_full <= 1'b1;
      end
   end

   assign out_valid = out_full;
   assign ExtImm    = out_reg.imm;
   assign illegal   = out_reg.illegal;
   assign out_tag   = out_reg.tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: 32- and 64-bit instances, directed vectors.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_valid64;
   logic [31:0] instr;
   logic [2:0]  src;
   logic [7:0]  tag;
   logic        out_ready;
   logic        out_ready64;

   logic        in_ready, out_valid, illegal;
   logic [31:0] ext32;
   logic [7:0]  out_tag;
   logic        in_ready64, out_valid64, illegal64;
   logic [63:0] ext64;
   logic [7:0]  out_tag64;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] imm;
      logic        ill;
      logic [7:0]  tag;
   } exp_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [2:0]  src;
      logic [7:0]  tag;
      logic [63:0] imm;
      logic        ill;
   } vec_t;

   exp_t q32[$];
   exp_t q64[$];
   vec_t v32[13];
   vec_t v64[4];

   always #5 clk = ~clk;

   imm_extend_pipe #(.DATA_WIDTH(32), .IMM_WIDTH(3), .TAG_WIDTH(8)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .ImmSrc(src), .in_tag(tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .ExtImm(ext32), .illegal(illegal), .out_tag(out_tag)
   );

   imm_extend_pipe #(.DATA_WIDTH(64), .IMM_WIDTH(3), .TAG_WIDTH(8)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid64), .in_ready(in_ready64),
      .instr(instr), .ImmSrc(src), .in_tag(tag),
      .out_valid(out_valid64), .out_ready(out_ready64),
      .ExtImm(ext64), .illegal(illegal64), .out_tag(out_tag64)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      in_valid64 = 1'b0;
   endtask

   // Holds the vector on the input until accepted; expectation is queued at the accepting edge.
   task automatic send(input bit w, input logic [31:0] i, input logic [2:0] s, input logic [7:0] t,
                       input logic [63:0] e, input logic il);
      bit   done = 1'b0;
      exp_t x;
      instr = i;
      src   = s;
      tag   = t;
      if (w) in_valid64 = 1'b1;
      else   in_valid   = 1'b1;
      x.imm = e;
      x.ill = il;
      x.tag = t;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (w ? in_ready64 : in_ready) begin
            done = 1'b1;
            if (w) q64.push_back(x);
            else   q32.push_back(x);
         end
         step();
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: tag %h not accepted, required acceptance within 50 cycles", t);
      end
   endtask

   logic        stall_prev = 1'b0;
   logic [31:0] prev_imm;
   logic        prev_ill;
   logic [7:0]  prev_tag;

   always @(negedge clk) begin
      if (stall_prev) begin
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_imm", ext32, prev_imm);
         chk("stall_ill", illegal, prev_ill);
         chk("stall_tag", out_tag, prev_tag);
      end
      stall_prev = out_valid && !out_ready && !rst && !flush;
      prev_imm   = ext32;
      prev_ill   = illegal;
      prev_tag   = out_tag;

      if (!rst && !flush && out_valid && out_ready) begin
         if (q32.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out32: tag %h presented, required no output", out_tag);
         end else begin
            exp_t e;
            e = q32.pop_front();
            chk("imm32", {32'h0, ext32}, e.imm);
            chk("ill32", illegal, e.ill);
            chk("tag32", out_tag, e.tag);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && !flush && out_valid64 && out_ready64) begin
         if (q64.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out64: tag %h presented, required no output", out_tag64);
         end else begin
            exp_t e;
            e = q64.pop_front();
            chk("imm64", ext64, e.imm);
            chk("ill64", illegal64, e.ill);
            chk("tag64", out_tag64, e.tag);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      v32 = '{
         '{32'hFE112E23, 3'd1, 8'h12, 64'hFFFFFFFC, 1'b0},
         '{32'h12345037, 3'd4, 8'h13, 64'h12345000, 1'b0},
         '{32'h00F00073, 3'd6, 8'h14, 64'h00000000, 1'b0},
         '{32'h01F0D093, 3'd5, 8'h15, 64'h0000001F, 1'b0},
         '{32'h03F09093, 3'd5, 8'h16, 64'h0000001F, 1'b0},
         '{32'h00208463, 3'd2, 8'h17, 64'h00000008, 1'b0},
         '{32'hFE000EE3, 3'd2, 8'h18, 64'hFFFFFFFC, 1'b0},
         '{32'h008000EF, 3'd3, 8'h19, 64'h00000008, 1'b0},
         '{32'hFFDFF0EF, 3'd3, 8'h1A, 64'hFFFFFFFC, 1'b0},
         '{32'h00500093, 3'd0, 8'h1B, 64'h00000005, 1'b0},
         '{32'h000FD073, 3'd6, 8'h1D, 64'h0000001F, 1'b0},
         '{32'hFFFFFFFF, 3'd7, 8'hA5, 64'h00000000, 1'b1},
         '{32'hFFF00093, 3'd0, 8'h1C, 64'hFFFFFFFF, 1'b0}
      };
      v64 = '{
         '{32'h80000037, 3'd4, 8'h21, 64'hFFFFFFFF80000000, 1'b0},
         '{32'h03F09093, 3'd5, 8'h22, 64'h000000000000003F, 1'b0},
         '{32'hFFF00093, 3'd0, 8'h23, 64'hFFFFFFFFFFFFFFFF, 1'b0},
         '{32'hFFFFFFFF, 3'd7, 8'h24, 64'h0000000000000000, 1'b1}
      };

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid64 = 1'b0;
      instr = '0; src = '0; tag = '0; out_ready = 1'b1; out_ready64 = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_imm", {32'h0, ext32}, 64'h0);
      chk("rst_ill", illegal, 1'b0);
      chk("rst_tag", out_tag, 8'h0);
      chk("rst_out_valid64", out_valid64, 1'b0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1'b1);
      step();

      // Latency from empty
      send(1'b0, 32'hFFF00093, 3'd0, 8'h11, 64'hFFFFFFFF, 1'b0);
      idle();
      @(negedge clk);
      chk("latency_valid", out_valid, 1'b1);
      step();

      // Format table, back to back
      foreach (v32[n]) send(1'b0, v32[n].instr, v32[n].src, v32[n].tag, v32[n].imm, v32[n].ill);
      idle();
      repeat (4) step();

      // Back-pressure: tags 1..6, out_ready low during cycles 3-6
      fork
         begin
            for (int t = 1; t <= 6; t++)
               send(1'b0, {12'(t), 20'h00093}, 3'd0, 8'(t), 64'(t), 1'b0);
            idle();
         end
         begin
            out_ready = 1'b1;
            step();
            step();
            out_ready = 1'b0;
            @(negedge clk);
            chk("bp_ready_c3", in_ready, 1'b1);
            step();
            @(negedge clk);
            chk("bp_ready_c4", in_ready, 1'b0);
            step();
            step();
            step();
            out_ready = 1'b1;
            @(negedge clk);
            chk("bp_ready_c7", in_ready, 1'b0);
            step();
            @(negedge clk);
            chk("bp_ready_c8", in_ready, 1'b1);
         end
      join
      repeat (6) step();
      chk("bp_drained", q32.size(), 0);

      // Flush with OUT and SKID full and an input offered
      out_ready = 1'b0;
      send(1'b0, 32'h03100093, 3'd0, 8'h31, 64'h31, 1'b0);
      send(1'b0, 32'h03200093, 3'd0, 8'h32, 64'h32, 1'b0);
      instr = 32'h0CC00093; src = 3'd0; tag = 8'hCC; in_valid = 1'b1;
      flush = 1'b1;
      q32.delete();
      step();
      flush = 1'b0;
      idle();
      @(negedge clk);
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_ready", in_ready, 1'b1);
      step();
      out_ready = 1'b1;
      repeat (4) step();
      send(1'b0, 32'h04100093, 3'd0, 8'h41, 64'h41, 1'b0);
      idle();
      repeat (3) step();

      // Reset while stalled with two entries
      out_ready = 1'b0;
      send(1'b0, 32'h05100093, 3'd0, 8'h51, 64'h51, 1'b0);
      send(1'b0, 32'h05200093, 3'd0, 8'h52, 64'h52, 1'b0);
      idle();
      rst = 1'b1;
      q32.delete();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_stall_valid", out_valid, 1'b0);
      chk("rst_stall_imm", {32'h0, ext32}, 64'h0);
      chk("rst_stall_ready", in_ready, 1'b1);
      step();
      out_ready = 1'b1;
      send(1'b0, 32'h06100093, 3'd0, 8'h61, 64'h61, 1'b0);
      idle();
      @(negedge clk);
      chk("rst_first_latency", out_valid, 1'b1);
      step();
      repeat (3) step();

      // 64-bit instance
      foreach (v64[n]) send(1'b1, v64[n].instr, v64[n].src, v64[n].tag, v64[n].imm, v64[n].ill);
      idle();
      repeat (4) step();

      chk("drain32", q32.size(), 0);
      chk("drain64", q64.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate generator sitting between the decode and execute stages. It accepts a 32-bit instruction word plus an `ImmSrc` select through a valid/ready handshake, and produces the extended immediate one cycle later. Output width is `DATA_WIDTH` (32 or 64), and three formats are added: shift amount, CSR zimm and an illegal flag. A 2-entry skid buffer lets back-pressure from execute stall the stage without dropping instructions. A synchronous flush clears all in-flight entries for branch redirects.

## Interface
- `DATA_WIDTH`, 32: width of `ExtImm`; legal values are 32 or 64.
- `IMM_WIDTH`, 3: width of `ImmSrc`.
- `TAG_WIDTH`, 8: sideband (e.g. rd/PC index) carried alongside each entry.
- One clock; reset is synchronous and active-high.
- `clk`  in  1: clock, all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `flush`  in  1: synchronous clear of all buffered entries.
- `in_valid`  in  1: `instr`/`ImmSrc`/`in_tag` are valid.
- `in_ready`  out  1: stage can accept this cycle.
- `instr`  in  32: instruction word.
- `ImmSrc`  in  `IMM_WIDTH`: format select.
- `in_tag`  in  `TAG_WIDTH`: sideband.
- `out_valid`  out  1: `ExtImm`/`illegal`/`out_tag` are valid.
- `out_ready`  in  1: execute consumes this cycle.
- `ExtImm`  out  `DATA_WIDTH`: extended immediate.
- `illegal`  out  1: `ImmSrc` was 3'b111.
- `out_tag`  out  `TAG_WIDTH`: sideband passthrough.

## Operation
- Formats; "sx" means sign-replicate `instr[31]` to `DATA_WIDTH`:
  - 000 I: sx(`instr[31:20]`).
  - 001 S: sx(`{instr[31:25], instr[11:7]}`).
  - 010 B: sx(`{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`).
  - 011 J: sx(`{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}`).
  - 100 U: sx(`{instr[31:12], 12'b0}`). Upper 32 bits are replicated `instr[31]` when `DATA_WIDTH`=64.
  - 101 SHAMT: zero-extend `instr[24:20]` (`DATA_WIDTH`=32) or `instr[25:20]` (64).
  - 110 ZIMM: zero-extend `instr[19:15]`.
  - 111: `ExtImm`=0 and `illegal`=1.
- Extension is computed combinationally at input and registered on acceptance.
- Storage:
  - Output register (OUT) drives the outputs.
  - Skid register (SKID) holds one extra entry.
  - Each has a valid bit.
- Transfer rules:
  - Input is accepted when `in_valid && in_ready`.
  - Output is consumed when `out_valid && out_ready`.
  - OUT is empty, or being consumed: OUT loads from SKID if SKID is valid, otherwise from the accepted input. Any accepted input then goes to SKID.
  - OUT is valid and not consumed: the accepted input goes to SKID.
  - `in_ready` = !SKID.valid && !`rst`. It is combinational from state only and never depends on `out_ready`.
- Ordering: strictly FIFO; no entry is ever dropped or duplicated except by `flush`/`rst`.
- Flush clears both valid bits; any input offered in the flush cycle is discarded. `in_ready` is 1 in the cycle after a flush.
- Priority: `rst` > `flush` > normal transfer.

## Timing
- Reset values: `out_valid`=0, `ExtImm`=0, `illegal`=0, `out_tag`=0, SKID.valid=0. `in_ready`=0 while `rst`=1 and 1 in the first cycle after.
- Latency: with OUT empty, input accepted at edge N gives `out_valid`=1 with the result after edge N.
- Throughput: one entry per cycle with `out_ready` held at 1.
- Back-pressure:
  - `out_ready`=0 with OUT valid: one more input is absorbed into SKID, then `in_ready` drops on the next cycle.
  - `out_ready`=1 again: OUT takes SKID, and `in_ready` returns to 1 the following cycle.
- Output stability: while `out_valid && !out_ready`, `ExtImm`/`illegal`/`out_tag` hold their values.
- Reset mid-stall: all entries are discarded and outputs return to their reset values after the edge.

## Test plan
- `DATA_WIDTH`=32, `out_ready`=1:
  - `instr`=0xFFF00093, `ImmSrc`=000 gives `ExtImm`=0xFFFFFFFF one cycle later.
  - 0xFE112E23/001 gives 0xFFFFFFFC.
  - 0x12345037/100 gives 0x12345000.
  - 0x00F00073/110 gives 0x00000000.
  - 0x01F0D093/101 gives 0x0000001F.
- `DATA_WIDTH`=64:
  - 0x80000037/100 gives 0xFFFFFFFF80000000.
  - 0x03F09093/101 gives 0x000000000000003F.
- Back-pressure: stream tags 1..6 back to back with `out_ready` low for cycles 3-6.
  - `in_ready` falls one cycle after SKID fills.
  - Outputs hold stable while stalled.
  - Tags emerge exactly as 1..6 with no loss or duplication.
- Flush with both OUT and SKID valid and `in_valid`=1 the same cycle: next cycle `out_valid`=0, `in_ready`=1, and the flushed input never appears.
- `ImmSrc`=111 with `instr`=0xFFFFFFFF: `ExtImm`=0, `illegal`=1, tag preserved. The next legal entry has `illegal`=0.
- `rst` asserted while stalled with 2 entries: the following cycle `out_valid`=0, `ExtImm`=0 and `in_ready`=1, and the first post-reset input appears after 1 cycle.
